// File: rtl/bound_flasher_gen.sv
// Parametrised multi-phase bound flasher with step prescaler.
// Drives a thermometer-coded LED bar through six fill/drain phases.
module bound_flasher_gen #(
    parameter int N_LED    = 16,
    parameter int B1       = 5,
    parameter int B2       = 10,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    input  logic             repeat_en,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase
);

    localparam int LW = $clog2(N_LED + 1);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [LW-1:0] L_B1   = LW'(B1);
    localparam logic [LW-1:0] L_B1P  = LW'(B1 + 1);
    localparam logic [LW-1:0] L_B2P  = LW'(B2 + 1);
    localparam logic [LW-1:0] L_FULL = LW'(N_LED);
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    if (N_LED < 4 || B1 < 1 || B2 <= B1 || B2 > N_LED - 2 || TICK_DIV < 1) begin : g_bad_params
        $error("bound_flasher_gen: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4,
        UP3  = 3'd5,
        DN3  = 3'd6
    } state_t;

    state_t        state, state_nx;
    logic [LW-1:0] lvl, lvl_nx;
    logic [LW-1:0] lvl_inc, lvl_dec;
    logic [CW-1:0] cnt, cnt_nx;
    logic          done_nx;
    logic          tick;

    assign tick    = (state != IDLE) && (cnt == C_LAST);
    assign lvl_inc = lvl + LW'(1);
    assign lvl_dec = lvl - LW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lvl   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            lvl   <= lvl_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        lvl_nx   = lvl;
        done_nx  = 1'b0;
        if (state == IDLE || tick) cnt_nx = '0;
        else                       cnt_nx = cnt + CW'(1);

        unique case (state)
            IDLE: begin
                if (flick) begin
                    state_nx = UP1;
                    lvl_nx   = LW'(1);
                end
            end
            UP1: begin
                if (tick) begin
                    lvl_nx = lvl_inc;
                    if (lvl_inc == L_B1P) state_nx = DN1;
                end
            end
            DN1: begin
                if (tick) begin
                    lvl_nx = lvl_dec;
                    if (lvl_dec == '0) state_nx = UP2;
                end
            end
            UP2: begin
                if (tick) begin
                    // kickback holds the level; the drain starts next tick
                    if (flick && lvl == L_B1P) begin
                        state_nx = DN1;
                    end else begin
                        lvl_nx = lvl_inc;
                        if (lvl_inc == L_B2P) state_nx = flick ? DN1 : DN2;
                    end
                end
            end
            DN2: begin
                if (tick) begin
                    lvl_nx = lvl_dec;
                    if (lvl_dec == L_B1) state_nx = UP3;
                end
            end
            UP3: begin
                if (tick) begin
                    if (flick && (lvl == L_B1P || lvl == L_B2P)) begin
                        state_nx = DN2;
                    end else begin
                        lvl_nx = lvl_inc;
                        if (lvl_inc == L_FULL) state_nx = DN3;
                    end
                end
            end
            DN3: begin
                if (tick) begin
                    lvl_nx = lvl_dec;
                    if (lvl_dec == '0) begin
                        done_nx  = 1'b1;
                        state_nx = repeat_en ? UP1 : IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                lvl_nx   = '0;
            end
        endcase
    end

    always_comb begin
        led = '0;
        for (int i = 0; i < N_LED; i++) led[i] = (i < int'(lvl));
    end

    assign busy  = (state != IDLE);
    assign phase = 3'(state);

endmodule
